// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, streams reads to synchronous instruction
// memory and buffers returned words in a 2-entry queue in front of decode.
module inst_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2
);

   // Handshake: an entry moves to decode in any cycle where if_valid and
   // if_ready are both high at the rising edge; if_instr/if_pc hold while stalled.

   logic [15:0] fetch_pc;
   logic [15:0] inflight_pc;
   logic        inflight;
   logic [15:0] q_instr [2];
   logic [15:0] q_pc    [2];
   logic        head;
   logic        tail;
   logic [1:0]  count;
   logic        pop;
   logic        push;
   logic [2:0]  occ_next;
   logic        unused_pc_bit0;

   assign unused_pc_bit0 = redirect_pc[0];

   assign if_valid    = (count != 2'd0);
   assign if_instr    = q_instr[head];
   assign if_pc       = q_pc[head];
   assign if_pc_plus2 = q_pc[head] + 16'd2;

   assign pop  = if_valid & if_ready;
   assign push = inflight & ~redirect_valid;

   // Occupancy after this cycle's pop, counting the response still on its way;
   // issuing only below 2 means every response is guaranteed a free slot.
   assign occ_next  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign imem_req  = rst_n & ~redirect_valid & (occ_next < 3'd2);
   assign imem_addr = fetch_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= {RESET_PC[15:1], 1'b0};
         inflight    <= 1'b0;
         inflight_pc <= 16'h0000;
         count       <= 2'd0;
         head        <= 1'b0;
         tail        <= 1'b0;
         q_instr[0]  <= 16'h0000;
         q_instr[1]  <= 16'h0000;
         q_pc[0]     <= 16'h0000;
         q_pc[1]     <= 16'h0000;
      end else if (redirect_valid) begin
         // Younger work is discarded, including the response arriving now.
         count    <= 2'd0;
         head     <= 1'b0;
         tail     <= 1'b0;
         inflight <= 1'b0;
         fetch_pc <= {redirect_pc[15:1], 1'b0};
      end else begin
         if (push) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= inflight_pc;
            tail          <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         count    <= count + {1'b0, push} - {1'b0, pop};
         inflight <= imem_req;
         if (imem_req) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 16'd2;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed phases plus a random redirect/backpressure run,
// with a scoreboard of expected {pc, instr} pairs checked by an independent monitor.
module tb_inst_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;

   int total = 0;
   int bad   = 0;
   int n_pop = 0;

   logic [31:0] exp_q[$];
   logic [15:0] next_pc;

   inst_fetch #(.RESET_PC(16'h0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus2    (if_pc_plus2)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous instruction memory: word = 16'h1000 + address, one cycle later.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= 16'h1000 + imem_addr;
      else          imem_rdata <= 16'hDEAD;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 4) begin
         exp_q.push_back({next_pc, 16'h1000 + next_pc});
         next_pc = next_pc + 16'd2;
      end
   endtask

   task automatic flush(input logic [15:0] start);
      exp_q.delete();
      next_pc = start;
      top_up();
   endtask

   // Advance one cycle; a redirect driven in the finished cycle restarts the stream.
   task automatic tick();
      @(posedge clk);
      #1;
      if (redirect_valid) flush({redirect_pc[15:1], 1'b0});
      top_up();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && if_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL deliver_extra got pc=%h instr=%h exp=none", if_pc, if_instr);
         end else if (if_ready) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_pop++;
            chk("deliver_pc_instr", {if_pc, if_instr}, e);
            chk("deliver_pc_plus2", {16'h0000, if_pc_plus2}, {16'h0000, e[31:16] + 16'd2});
         end else begin
            chk("stall_head", {if_pc, if_instr}, exp_q[0]);
         end
      end
   end

   // driver
   initial begin
      logic [15:0] head_pc;
      int          pops_before;
      logic        rv;
      logic        prev_rv;
      logic [15:0] tgt;

      rst_n = 1'b0;
      if_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 16'h0000;
      next_pc = 16'h0000;
      imem_rdata = 16'h0000;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", {16'd0, if_instr}, 32'h0);
      chk("rst_pc", {16'd0, if_pc}, 32'h0);
      chk("rst_pc_plus2", {16'd0, if_pc_plus2}, 32'h2);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      tick();
      rst_n = 1'b1;
      flush(16'h0000);

      // first fetch timing and free flow
      @(negedge clk);
      chk("t0_req", {31'd0, imem_req}, 32'd1);
      chk("t0_addr", {16'd0, imem_addr}, 32'h0);
      chk("t0_valid", {31'd0, if_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("t1_valid", {31'd0, if_valid}, 32'd0);
      chk("t1_addr", {16'd0, imem_addr}, 32'h2);
      tick();
      @(negedge clk);
      chk("t2_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_pc", {16'd0, if_pc}, 32'h0);
      tick();
      repeat (6) begin
         @(negedge clk);
         chk("stream_gap", {31'd0, if_valid}, 32'd1);
         tick();
      end

      // backpressure: two entries buffered, head frozen
      if_ready = 1'b0;
      head_pc = exp_q[0][31:16];
      repeat (5) begin
         @(negedge clk);
         chk("bp_req", {31'd0, imem_req}, 32'd0);
         chk("bp_valid", {31'd0, if_valid}, 32'd1);
         chk("bp_pc", {16'd0, if_pc}, {16'd0, head_pc});
         tick();
      end
      if_ready = 1'b1;
      @(negedge clk);
      chk("bp_resume_req", {31'd0, imem_req}, 32'd1);
      tick();

      // redirect with a full queue, coinciding with a pop
      if_ready = 1'b0;
      tick();
      if_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0041;
      @(negedge clk);
      chk("rd_req", {31'd0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("rd1_req", {31'd0, imem_req}, 32'd1);
      chk("rd1_addr", {16'd0, imem_addr}, 32'h0040);
      chk("rd1_valid", {31'd0, if_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("rd2_valid", {31'd0, if_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("rd3_valid", {31'd0, if_valid}, 32'd1);
      chk("rd3_pc", {16'd0, if_pc}, 32'h0040);
      tick();
      repeat (3) tick();

      // address wrap
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFC;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_addr0", {16'd0, imem_addr}, 32'hFFFC);
      tick();
      @(negedge clk);
      chk("wrap_addr1", {16'd0, imem_addr}, 32'hFFFE);
      tick();
      @(negedge clk);
      chk("wrap_addr2", {16'd0, imem_addr}, 32'h0000);
      chk("wrap_pc0", {16'd0, if_pc}, 32'hFFFC);
      tick();
      @(negedge clk);
      chk("wrap_addr3", {16'd0, imem_addr}, 32'h0002);
      chk("wrap_pc1", {16'd0, if_pc}, 32'hFFFE);
      chk("wrap_plus2", {16'd0, if_pc_plus2}, 32'h0000);
      tick();
      repeat (2) tick();

      // reset mid-stream with a full queue
      if_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_req_now", {31'd0, imem_req}, 32'd0);
      tick();
      @(negedge clk);
      chk("mrst_valid", {31'd0, if_valid}, 32'd0);
      chk("mrst_req", {31'd0, imem_req}, 32'd0);
      tick();
      rst_n = 1'b1;
      if_ready = 1'b1;
      flush(16'h0000);
      @(negedge clk);
      chk("mrst_t0_addr", {16'd0, imem_addr}, 32'h0000);
      chk("mrst_t0_valid", {31'd0, if_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("mrst_t1_valid", {31'd0, if_valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("mrst_t2_pc", {16'd0, if_pc}, 32'h0000);
      chk("mrst_t2_valid", {31'd0, if_valid}, 32'd1);
      tick();

      // random decode stalls and redirect pulses
      pops_before = n_pop;
      prev_rv = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         rv = ($urandom_range(0, 15) == 0) && !prev_rv;
         tgt = 16'($urandom_range(0, 65535));
         redirect_valid = rv;
         redirect_pc = tgt;
         if_ready = ($urandom_range(0, 3) != 0);
         prev_rv = rv;
         tick();
      end
      redirect_valid = 1'b0;
      if_ready = 1'b1;
      repeat (6) tick();
      @(negedge clk);
      chk("drain_valid", {31'd0, if_valid}, 32'd1);
      chk("random_throughput", {31'd0, (n_pop - pops_before) > 2000}, 32'd1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
